// File: rtl/reg_file_mp.sv
// Multi-port register file with integrated PC (top index), two write ports,
// optional same-cycle write-to-read bypass and a pending-load busy scoreboard.
module reg_file_mp #(
    parameter int                 DATA_W   = 32,
    parameter int                 DEPTH    = 16,
    parameter int                 NUM_RD   = 4,
    parameter int                 BYPASS   = 1,
    parameter logic [DATA_W-1:0]  RESET_PC = '0,
    localparam int                AW       = $clog2(DEPTH)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_RD*AW-1:0]       rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_busy,
    input  logic                       wa_en,
    input  logic [AW-1:0]              wa_addr,
    input  logic [DATA_W-1:0]          wa_data,
    input  logic                       wm_en,
    input  logic [AW-1:0]              wm_addr,
    input  logic [DATA_W-1:0]          wm_data,
    input  logic                       lock_en,
    input  logic [AW-1:0]              lock_addr,
    input  logic                       pc_en,
    input  logic [DATA_W-1:0]          pc_next,
    output logic [DATA_W-1:0]          pc_out,
    output logic                       any_busy
);
    localparam bit BYP = (BYPASS != 0);

    logic [DEPTH-1:0][DATA_W-1:0] r_regs;
    logic [DEPTH-1:0]             r_busy;
    logic                         w_wa_vld;
    logic                         w_wm_vld;

    // Bypass paths are gated by reset so reads show only the cleared state.
    assign w_wa_vld = wa_en & rst_n;
    assign w_wm_vld = wm_en & rst_n;

    // Priority per register: ALU port, then DMEM port, then PC update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < DEPTH-1; j++)
                r_regs[j] <= '0;
            r_regs[DEPTH-1] <= RESET_PC;
        end else begin
            for (int j = 0; j < DEPTH; j++) begin
                if (wa_en && wa_addr == AW'(j))
                    r_regs[j] <= wa_data;
                else if (wm_en && wm_addr == AW'(j))
                    r_regs[j] <= wm_data;
                else if (j == DEPTH-1 && pc_en)
                    r_regs[j] <= pc_next;
            end
        end
    end

    // Lock set beats writeback clear; the PC never becomes busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else begin
            for (int j = 0; j < DEPTH-1; j++) begin
                if (lock_en && lock_addr == AW'(j))
                    r_busy[j] <= 1'b1;
                else if (wm_en && wm_addr == AW'(j))
                    r_busy[j] <= 1'b0;
            end
            r_busy[DEPTH-1] <= 1'b0;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [AW-1:0] w_addr;
        logic          w_hit_wa;
        logic          w_hit_wm;

        assign w_addr   = rd_addr[i*AW +: AW];
        assign w_hit_wa = BYP && w_wa_vld && (wa_addr == w_addr);
        assign w_hit_wm = BYP && w_wm_vld && (wm_addr == w_addr);

        assign rd_data[i*DATA_W +: DATA_W] = w_hit_wa ? wa_data :
                                             w_hit_wm ? wm_data : r_regs[w_addr];
        assign rd_busy[i] = r_busy[w_addr] & ~w_hit_wm;
    end

    assign pc_out   = r_regs[DEPTH-1];
    assign any_busy = |r_busy;

endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard bench: two instances (bypass 32b x4 ports, registered 16b x2 ports)
// share one stimulus stream; a reference model predicts every cycle's outputs.
module tb_reg_file_mp;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst_n;
    logic [3:0][3:0]      rd_addr;
    logic [7:0]           rd_addr_b;
    logic                 wa_en, wm_en, lock_en, pc_en;
    logic [3:0]           wa_addr, wm_addr, lock_addr;
    logic [31:0]          wa_data, wm_data, pc_next;

    logic [3:0][31:0]     rd_data_a;
    logic [3:0]           rd_busy_a;
    logic [31:0]          pc_out_a;
    logic                 any_busy_a;
    logic [1:0][15:0]     rd_data_b;
    logic [1:0]           rd_busy_b;
    logic [15:0]          pc_out_b;
    logic                 any_busy_b;

    assign rd_addr_b = {rd_addr[1], rd_addr[0]};

    reg_file_mp #(.DATA_W(32), .DEPTH(16), .NUM_RD(4), .BYPASS(1), .RESET_PC(32'h100)) u_a (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_busy(rd_busy_a),
        .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
        .wm_en(wm_en), .wm_addr(wm_addr), .wm_data(wm_data),
        .lock_en(lock_en), .lock_addr(lock_addr), .pc_en(pc_en), .pc_next(pc_next),
        .pc_out(pc_out_a), .any_busy(any_busy_a));

    reg_file_mp #(.DATA_W(16), .DEPTH(16), .NUM_RD(2), .BYPASS(0), .RESET_PC(16'h0040)) u_b (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr_b), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
        .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data[15:0]),
        .wm_en(wm_en), .wm_addr(wm_addr), .wm_data(wm_data[15:0]),
        .lock_en(lock_en), .lock_addr(lock_addr), .pc_en(pc_en), .pc_next(pc_next[15:0]),
        .pc_out(pc_out_b), .any_busy(any_busy_b));

    typedef struct {
        int               tag;
        logic [3:0][31:0] rd;
        logic [3:0]       bsy;
        logic             any;
        logic [31:0]      pc;
        logic [1:0][15:0] rdb;
        logic [1:0]       bsyb;
        logic             anyb;
        logic [15:0]      pcb;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference state: architectural registers and pending-load flags.
    logic [31:0] ma [16];
    logic [15:0] ma_busy;
    logic [15:0] mb [16];
    logic [15:0] mb_busy;

    // Stimulus intent for the next cycle.
    logic            t_rst;
    logic [3:0][3:0] t_addr;
    logic            t_wa_en, t_wm_en, t_lock_en, t_pc_en;
    logic [3:0]      t_wa_addr, t_wm_addr, t_lock_addr;
    logic [31:0]     t_wa_data, t_wm_data, t_pc_next;

    task automatic idle();
        t_wa_en = 0; t_wm_en = 0; t_lock_en = 0; t_pc_en = 0;
        t_wa_addr = 0; t_wm_addr = 0; t_lock_addr = 0;
        t_wa_data = 0; t_wm_data = 0; t_pc_next = 0;
    endtask

    task automatic issue(input int tag);
        exp_t e;
        logic wa, wm, lk;
        @(posedge clk); #1;
        rst_n = t_rst; rd_addr = t_addr;
        wa_en = t_wa_en; wa_addr = t_wa_addr; wa_data = t_wa_data;
        wm_en = t_wm_en; wm_addr = t_wm_addr; wm_data = t_wm_data;
        lock_en = t_lock_en; lock_addr = t_lock_addr;
        pc_en = t_pc_en; pc_next = t_pc_next;
        if (!t_rst) begin
            for (int j = 0; j < 16; j++) begin ma[j] = 0; mb[j] = 0; end
            ma[15] = 32'h100; mb[15] = 16'h0040;
            ma_busy = 0; mb_busy = 0;
        end
        wa = t_wa_en && t_rst; wm = t_wm_en && t_rst; lk = t_lock_en && t_rst;
        e.tag = tag;
        for (int i = 0; i < 4; i++) begin
            if (wa && t_wa_addr == t_addr[i])      e.rd[i] = t_wa_data;
            else if (wm && t_wm_addr == t_addr[i]) e.rd[i] = t_wm_data;
            else                                   e.rd[i] = ma[t_addr[i]];
            e.bsy[i] = ma_busy[t_addr[i]] && !(wm && t_wm_addr == t_addr[i]);
        end
        for (int i = 0; i < 2; i++) begin
            e.rdb[i]  = mb[t_addr[i]];
            e.bsyb[i] = mb_busy[t_addr[i]];
        end
        e.any = |ma_busy; e.pc = ma[15];
        e.anyb = |mb_busy; e.pcb = mb[15];
        q.push_back(e);
        for (int j = 0; j < 16; j++) begin
            if (wa && t_wa_addr == j) begin
                ma[j] = t_wa_data; mb[j] = t_wa_data[15:0];
            end else if (wm && t_wm_addr == j) begin
                ma[j] = t_wm_data; mb[j] = t_wm_data[15:0];
            end else if (j == 15 && t_pc_en && t_rst) begin
                ma[j] = t_pc_next; mb[j] = t_pc_next[15:0];
            end
            if (lk && t_lock_addr == j && j != 15) begin
                ma_busy[j] = 1; mb_busy[j] = 1;
            end else if (wm && t_wm_addr == j) begin
                ma_busy[j] = 0; mb_busy[j] = 0;
            end
        end
    endtask

    task automatic chk(input string nm, input int tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s tag=%0d got=%h want=%h", nm, tag, act, exp);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                for (int i = 0; i < 4; i++) begin
                    chk($sformatf("A.rd_data[%0d]", i), e.tag, rd_data_a[i], e.rd[i]);
                    chk($sformatf("A.rd_busy[%0d]", i), e.tag, 32'(rd_busy_a[i]), 32'(e.bsy[i]));
                end
                chk("A.pc_out", e.tag, pc_out_a, e.pc);
                chk("A.any_busy", e.tag, 32'(any_busy_a), 32'(e.any));
                for (int i = 0; i < 2; i++) begin
                    chk($sformatf("B.rd_data[%0d]", i), e.tag, 32'(rd_data_b[i]), 32'(e.rdb[i]));
                    chk($sformatf("B.rd_busy[%0d]", i), e.tag, 32'(rd_busy_b[i]), 32'(e.bsyb[i]));
                end
                chk("B.pc_out", e.tag, 32'(pc_out_b), 32'(e.pcb));
                chk("B.any_busy", e.tag, 32'(any_busy_b), 32'(e.anyb));
            end
        end
    end

    function automatic logic [3:0] raddr();
        return ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(3, 7));
    endfunction

    initial begin : stim
        rst_n = 0; rd_addr = 0;
        wa_en = 0; wm_en = 0; lock_en = 0; pc_en = 0;
        wa_addr = 0; wm_addr = 0; lock_addr = 0;
        wa_data = 0; wm_data = 0; pc_next = 0;
        t_rst = 0; idle();
        t_addr = {4'd15, 4'd7, 4'd3, 4'd0};
        issue(1);
        t_wa_en = 1; t_wa_addr = 3; t_wa_data = 32'h1234; t_lock_en = 1; t_lock_addr = 3;
        issue(2);                                      // ignored while in reset
        t_rst = 1; idle(); issue(3);                   // release, pc=0x100
        t_addr = {4'd15, 4'd3, 4'd3, 4'd3};
        t_wa_en = 1; t_wa_addr = 3; t_wa_data = 32'hDEAD;
        t_wm_en = 1; t_wm_addr = 3; t_wm_data = 32'hBEEF;
        issue(4);
        idle(); issue(5);
        t_pc_en = 1; t_pc_next = 32'h104; t_wa_en = 1; t_wa_addr = 15; t_wa_data = 32'h200;
        issue(6);
        idle(); t_pc_en = 1; t_pc_next = 32'h204; issue(7);
        idle(); issue(8);
        t_addr = {4'd15, 4'd0, 4'd5, 4'd5};
        t_lock_en = 1; t_lock_addr = 5; issue(9);
        t_wm_en = 1; t_wm_addr = 5; t_wm_data = 32'h55; issue(10);
        idle(); t_wm_en = 1; t_wm_addr = 5; t_wm_data = 32'h55; issue(11);
        idle(); issue(12);
        t_addr = {4'd15, 4'd5, 4'd7, 4'd7};
        t_wa_en = 1; t_wa_addr = 7; t_wa_data = 32'hFFFF; t_lock_en = 1; t_lock_addr = 7;
        issue(13);
        idle(); issue(14);
        t_rst = 0; t_wa_en = 1; t_wa_addr = 7; t_wa_data = 32'h1; issue(15);
        t_rst = 1; idle(); issue(16);
        t_wa_en = 1; t_wa_addr = 7; t_wa_data = 32'h77; issue(17);
        for (int k = 0; k < 400; k++) begin
            t_rst = ($urandom_range(0, 63) != 0);
            for (int i = 0; i < 4; i++) t_addr[i] = raddr();
            t_wa_en = 1'($urandom_range(0, 1)); t_wa_addr = raddr(); t_wa_data = $urandom;
            t_wm_en = 1'($urandom_range(0, 1)); t_wm_addr = raddr(); t_wm_data = $urandom;
            t_lock_en = 1'($urandom_range(0, 1)); t_lock_addr = raddr();
            t_pc_en = 1'($urandom_range(0, 1)); t_pc_next = $urandom;
            issue(100 + k);
        end
        t_rst = 1; idle(); issue(999);
        repeat (4) @(negedge clk);
        n_cmp++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain got=%0d want=0 pending entries", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
